twiddle_gen: RTL and testbench

//  Parametrised twiddle-factor sequencer for radix-2 DIF FFT of N = 2**N_LOG2 points.

---
 rtl/twiddle_gen.sv | 92 +++++++++
 tb/tb_twiddle_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// twiddle_gen: radix-2 DIF FFT twiddle sequencer folding a quarter-wave cosine table into W_N^m.
// Streams N/2 twiddles per stage over valid/ready through a two-stage stallable pipeline.
module twiddle_gen #(
  parameter int N_LOG2 = 5,
  parameter int WIDTH  = 16,
  parameter int FRAC   = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              stage,
  input  logic                    inverse,
  input  logic                    tw_ready,
  output logic                    tw_valid,
  output logic signed [WIDTH-1:0] tw_re,
  output logic signed [WIDTH-1:0] tw_im,
  output logic [N_LOG2-2:0]       tw_idx,
  output logic                    tw_last,
  output logic                    busy,
  output logic                    err
);
  localparam int HW = N_LOG2 - 1;
  localparam int H  = 2 ** HW;
  localparam int Q  = 2 ** (N_LOG2 - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [HW-1:0]           c, p1_m, a_re, a_im;
  logic [3:0]              st;
  logic                    inv, p1_valid, p1_last, lo, en;
  logic signed [WIDTH-1:0] tbl [0:Q];

  function automatic int cval(int i);
    real x;
    x = (2.0 ** FRAC) * $cos(2.0 * 3.141592653589793 * i / (2.0 ** N_LOG2));
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  for (genvar i = 0; i <= Q; i++) begin : g_tbl
    localparam int V = cval(i);
    assign tbl[i] = WIDTH'(V);
  end

  // Both fold addresses land in 0..Q; modular HW-bit arithmetic gives N/2-m as -m.
  assign lo   = p1_m < HW'(Q);
  assign a_re = lo ? p1_m : -p1_m;
  assign a_im = lo ? HW'(Q) - p1_m : p1_m - HW'(Q);
  assign en   = !tw_valid || tw_ready;
  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      c        <= '0;
      st       <= '0;
      inv      <= 1'b0;
      p1_valid <= 1'b0;
      p1_m     <= '0;
      p1_last  <= 1'b0;
      tw_valid <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
      tw_idx   <= '0;
      tw_last  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= state == IDLE && start && stage >= 4'(N_LOG2);
      if (state == IDLE && start && stage < 4'(N_LOG2)) begin
        state <= RUN;
        st    <= stage;
        inv   <= inverse;
        c     <= '0;
      end
      if (en) begin
        p1_valid <= state == RUN;
        p1_m     <= c << st;
        p1_last  <= c == HW'(H - 1);
        tw_valid <= p1_valid;
        tw_idx   <= p1_m;
        tw_last  <= p1_last;
        tw_re    <= lo ? tbl[a_re] : -tbl[a_re];
        tw_im    <= inv ? tbl[a_im] : -tbl[a_im];
        if (state == RUN) begin
          c <= c + 1'b1;
          if (c == HW'(H - 1)) state <= DRAIN;
        end
      end
      if (state == DRAIN && tw_valid && tw_ready && tw_last) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed bench for twiddle_gen with a trigonometric reference model and a per-cycle checker.
module tb_twiddle_gen;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         stage = '0;
  logic               inverse = 1'b0;
  logic               tw_ready;
  logic               tw_valid;
  logic signed [15:0] tw_re, tw_im;
  logic [3:0]         tw_idx;
  logic               tw_last, busy, err;

  int  tests = 0;
  int  fails = 0;
  int  q[$];
  int  cap_re [16];
  int  cap_im [16];
  int  cap_idx[16];
  int  bn = 0;
  bit  rmode = 1'b0;
  bit  pstall = 1'b0;
  logic [37:0] snap;

  twiddle_gen #(.N_LOG2(5), .WIDTH(16), .FRAC(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
    .tw_ready(tw_ready), .tw_valid(tw_valid), .tw_re(tw_re), .tw_im(tw_im),
    .tw_idx(tw_idx), .tw_last(tw_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chki(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  function automatic int rnd(real x);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int exp_re(int m);
    return rnd(128.0 * $cos(2.0 * 3.141592653589793 * m / 32.0));
  endfunction

  function automatic int exp_im(int m, int iv);
    int s;
    s = rnd(128.0 * $sin(2.0 * 3.141592653589793 * m / 32.0));
    return iv != 0 ? s : -s;
  endfunction

  task automatic push_seq(input int s, input int iv);
    for (int k = 0; k < 16; k++)
      q.push_back(((k << s) & 15) | (int'(k == 15) << 8) | (iv << 9));
  endtask

  task automatic go(input int s, input int iv, input bit exp_run);
    start = 1'b1;
    stage = 4'(s);
    inverse = iv[0];
    if (exp_run) push_seq(s, iv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chki("idle_timeout", int'(busy), 0);
    chki("queue_drained", q.size(), 0);
  endtask

  initial begin
    tw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tw_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int e, m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bn = 0;
        pstall = 1'b0;
      end else begin
        if (pstall) chki("stall_stable", int'({tw_valid, tw_re, tw_im, tw_idx, tw_last} == snap), 1);
        if (tw_valid) chki("beat_expected", int'(q.size() > 0), 1);
        if (tw_valid && tw_ready && q.size() > 0) begin
          e = q.pop_front();
          m = e & 255;
          chki("re", tw_re, exp_re(m));
          chki("im", tw_im, exp_im(m, (e >> 9) & 1));
          chki("idx", int'(tw_idx), m);
          chki("last", int'(tw_last), (e >> 8) & 1);
          cap_re[bn] = tw_re;
          cap_im[bn] = tw_im;
          cap_idx[bn] = tw_idx;
          bn = ((e >> 8) & 1) != 0 ? 0 : (bn + 1) % 16;
        end
        pstall = tw_valid && !tw_ready;
        snap = {tw_valid, tw_re, tw_im, tw_idx, tw_last};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chki("reset_outputs", int'({tw_valid, tw_re, tw_im, tw_idx, tw_last, busy, err} == '0), 1);
    chki("model_pin_c3", exp_re(3), 106);
    chki("model_pin_s7", exp_im(7, 0), -126);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Forward FFT, stage 0, with latency check
    go(0, 0, 1'b1);
    chki("busy_after_start", int'(busy), 1);
    chki("valid_edge0", int'(tw_valid), 0);
    @(posedge clk); #1;
    chki("valid_edge1", int'(tw_valid), 0);
    @(posedge clk); #1;
    chki("valid_edge2", int'(tw_valid), 1);
    wait_idle();
    chki("t1_m0_re", cap_re[0], 128);
    chki("t1_m0_im", cap_im[0], 0);
    chki("t1_m1_re", cap_re[1], 126);
    chki("t1_m1_im", cap_im[1], -25);
    chki("t1_m4_re", cap_re[4], 91);
    chki("t1_m4_im", cap_im[4], -91);
    chki("t1_m8_re", cap_re[8], 0);
    chki("t1_m8_im", cap_im[8], -128);
    chki("t1_m12_re", cap_re[12], -91);
    chki("t1_m12_im", cap_im[12], -91);
    // Back-to-back stages 1 and 4
    go(1, 0, 1'b1);
    wait_idle();
    chki("s1_idx8", cap_idx[8], 0);
    chki("s1_idx9", cap_idx[9], 2);
    chki("s1_idx15", cap_idx[15], 14);
    go(4, 0, 1'b1);
    wait_idle();
    chki("s4_re15", cap_re[15], 128);
    chki("s4_im9", cap_im[9], 0);
    // Inverse
    go(0, 1, 1'b1);
    wait_idle();
    chki("inv_m1_re", cap_re[1], 126);
    chki("inv_m1_im", cap_im[1], 25);
    chki("inv_m12_re", cap_re[12], -91);
    chki("inv_m12_im", cap_im[12], 91);
    // Random backpressure
    rmode = 1'b1;
    go(2, 0, 1'b1);
    wait_idle();
    go(3, 1, 1'b1);
    wait_idle();
    rmode = 1'b0;
    @(posedge clk); #1;
    // Illegal stage
    go(5, 0, 1'b0);
    chki("err_pulse", int'(err), 1);
    chki("err_busy", int'(busy), 0);
    @(posedge clk); #1;
    chki("err_cleared", int'(err), 0);
    repeat (3) @(posedge clk);
    #1;
    // Start while busy is ignored
    go(0, 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    stage = 4'd3;
    inverse = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chki("busy_start_no_err", int'(err), 0);
    wait_idle();
    // Reset mid-sequence at beat 7
    go(0, 0, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(tw_valid && tw_idx == 4'd7) && n < 40);
    chki("reach_beat7", int'(tw_valid && tw_idx == 4'd7), 1);
    rst_n = 1'b0;
    #1;
    chki("async_reset_outputs", int'({tw_valid, tw_re, tw_im, tw_idx, tw_last, busy, err} == '0), 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(0, 0, 1'b1);
    wait_idle();
    chki("restart_idx0", cap_idx[0], 0);
    chki("restart_re1", cap_re[1], 126);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
